dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES wait
// states, then holds a registered response until the initiator takes it.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_mem_write,
  input  logic [2:0]            req_mem_read,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [AW+1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            wr_q;
  logic [2:0]            rd_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [AW-1:0]         idx;
  logic [1:0]            off;
  logic                  err;
  logic                  commit;
  logic                  unused_addr_hi;

  function automatic logic access_err(input logic [1:0] wr, input logic [2:0] rd,
                                      input logic [1:0] a);
    logic e;
    e = 1'b0;
    if (wr != 2'b00 && rd != 3'b000)                         e = 1'b1;
    if (rd == 3'b110 || rd == 3'b111)                        e = 1'b1;
    if ((wr == 2'b10 || rd == 3'b010 || rd == 3'b101) && a[0]) e = 1'b1;
    if ((wr == 2'b11 || rd == 3'b011) && a != 2'b00)         e = 1'b1;
    return e;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [2:0] rd,
                                                        input logic [1:0] a);
    logic signed [7:0]            b;
    logic signed [15:0]           h;
    logic signed [DATA_WIDTH-1:0] sx;
    logic [DATA_WIDTH-1:0]        r;
    b  = word[{a, 3'b000} +: 8];
    h  = word[{a[1], 4'b0000} +: 16];
    sx = '0;
    r  = '0;
    case (rd)
      3'b001:  begin sx = b; r = sx; end
      3'b010:  begin sx = h; r = sx; end
      3'b011:  r = word;
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] old,
                                                        input logic [DATA_WIDTH-1:0] wd,
                                                        input logic [1:0] wr,
                                                        input logic [1:0] a);
    logic [DATA_WIDTH-1:0] r;
    r = old;
    case (wr)
      2'b01:   r[{a, 3'b000} +: 8]     = wd[7:0];
      2'b10:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
      2'b11:   r = wd;
      default: r = old;
    endcase
    return r;
  endfunction

  // Address bits above the storage window alias onto the same words.
  assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:AW+2];

  assign idx        = addr_q[AW+1:2];
  assign off        = addr_q[1:0];
  assign err        = access_err(wr_q, rd_q, off);
  assign commit     = rst_n && (state == WAIT) && (cnt == 4'd0) && !err && (wr_q != 2'b00);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state <= WAIT;
          cnt   <= 4'(WAIT_CYCLES);
        end
        WAIT: if (cnt == 4'd0) begin
          state      <= RESP;
          resp_err   <= err;
          resp_rdata <= err ? '0 : load_extend(mem[idx], rd_q, off);
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture and storage carry no reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
      wr_q    <= req_mem_write;
      rd_q    <= req_mem_read;
    end
    if (commit) mem[idx] <= store_merge(mem[idx], wdata_q, wr_q, off);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with hand-computed expected values.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_mem_write;
  logic [2:0]  req_mem_read;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errs   = 0;

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mem_write(req_mem_write),
    .req_mem_read(req_mem_read), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // One full handshake; hold keeps resp_ready low for that many cycles in RESP.
  task automatic txn(input string tag, input logic [1:0] wr, input logic [2:0] rd,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    req_valid     = 1'b1;
    req_addr      = addr;
    req_wdata     = wdata;
    req_mem_write = wr;
    req_mem_read  = rd;
    resp_ready    = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) check({tag, "_timeout"}, {31'd0, resp_valid}, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid     = 1'b1;
      req_addr      = 32'h10;
      req_wdata     = 32'h0;
      req_mem_write = 2'b11;
      req_mem_read  = 3'b000;
      @(posedge clk); #1;
      check({tag, "_hold_vld"},   {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, rdata);
      check({tag, "_hold_rdy"},   {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic expect_txn(input string tag, input logic [1:0] wr, input logic [2:0] rd,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] d;
    logic        e;
    int          l;
    txn(tag, wr, rd, addr, wdata, 0, d, e, l);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_err"},  {31'd0, e}, {31'd0, exp_err});
    check({tag, "_lat"},  l, 32'd3);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          l;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_mem_write = 2'b00; req_mem_read = 3'b000; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_rdata",      resp_rdata,          32'd0);
    check("rst_err",        {31'd0, resp_err},   32'd0);

    expect_txn("sw10",   2'b11, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    expect_txn("lw10",   2'b00, 3'b011, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    expect_txn("sb11",   2'b01, 3'b000, 32'h11, 32'h80,       32'h0,        1'b0);
    expect_txn("lb11",   2'b00, 3'b001, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0);
    expect_txn("lbu11",  2'b00, 3'b100, 32'h11, 32'h0,        32'h00000080, 1'b0);
    expect_txn("lw10b",  2'b00, 3'b011, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0);
    expect_txn("lh13",   2'b00, 3'b010, 32'h13, 32'h0,        32'h0,        1'b1);
    expect_txn("sw12",   2'b11, 3'b000, 32'h12, 32'h0,        32'h0,        1'b1);
    expect_txn("lw10c",  2'b00, 3'b011, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0);
    expect_txn("sh12",   2'b10, 3'b000, 32'h12, 32'hFFFF8001, 32'h0,        1'b0);
    expect_txn("lh12",   2'b00, 3'b010, 32'h12, 32'h0,        32'hFFFF8001, 1'b0);
    expect_txn("lhu12",  2'b00, 3'b101, 32'h12, 32'h0,        32'h00008001, 1'b0);
    expect_txn("lb13",   2'b00, 3'b001, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0);
    expect_txn("lw10d",  2'b00, 3'b011, 32'h10, 32'h0,        32'h800180EF, 1'b0);
    expect_txn("lw11",   2'b00, 3'b011, 32'h11, 32'h0,        32'h0,        1'b1);
    expect_txn("rd110",  2'b00, 3'b110, 32'h10, 32'h0,        32'h0,        1'b1);
    expect_txn("both",   2'b01, 3'b001, 32'h10, 32'hFF,       32'h0,        1'b1);
    expect_txn("noop",   2'b00, 3'b000, 32'h10, 32'h0,        32'h0,        1'b0);
    expect_txn("lw10e",  2'b00, 3'b011, 32'h10, 32'h0,        32'h800180EF, 1'b0);

    // Response held off for 5 cycles while stray requests are presented.
    txn("hold", 2'b00, 3'b011, 32'h10, 32'h0, 5, d, e, l);
    check("hold_data", d, 32'h800180EF);
    check("hold_lat",  l, 32'd3);
    expect_txn("lw10f",  2'b00, 3'b011, 32'h10, 32'h0,        32'h800180EF, 1'b0);

    // Reset one cycle after accepting a store discards that store.
    expect_txn("sw20a",  2'b11, 3'b000, 32'h20, 32'h11111111, 32'h0,        1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_mem_write = 2'b11; req_mem_read = 3'b000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("wrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("wrst_req_ready",  {31'd0, req_ready},  32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("wrst_idle_vld", {31'd0, resp_valid}, 32'd0);
    expect_txn("lw20",   2'b00, 3'b011, 32'h20, 32'h0,        32'h11111111, 1'b0);

    expect_txn("sw400",  2'b11, 3'b000, 32'h400, 32'hA5A5A5A5, 32'h0,       1'b0);
    expect_txn("lw000",  2'b00, 3'b011, 32'h000, 32'h0,        32'hA5A5A5A5, 1'b0);
    expect_txn("lw10g",  2'b00, 3'b011, 32'h10,  32'h0,        32'h800180EF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
